core_fetch_buffer: RTL and testbench
====================================

# core_fetch_buffer

Instruction fetch buffer between the instruction-memory response port and the decode stage. It queues fetched words with their PC and fault status. It presents the oldest entry to decode as the instruction word and the fetch-side illegal flag. It also absorbs decode stalls and discards stale responses after a pipeline redirect (flush) using a 1-bit fetch epoch.

## Interface
- XLEN, 64, PC width in bits
- DEPTH, 2, number of buffer entries; must be a power of two and at least 2
- i_clk  input  1  core clock; all state updates on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_fb_flush  input  1  redirect: discard every buffered entry and toggle the epoch
- i_fb_mem_valid  input  1  memory response valid
- i_fb_mem_instr  input  32  fetched instruction word
- i_fb_mem_pc  input  XLEN  PC of the fetched word
- i_fb_mem_fault  input  1  instruction access fault on this fetch
- i_fb_mem_epoch  input  1  epoch tag the fetch unit attached when it issued the request
- o_fb_mem_ready  output  1  buffer can accept a response this cycle
- o_fb_epoch  output  1  current epoch; the fetch unit tags new requests with it
- o_fb_valid  output  1  head entry valid toward decode
- o_fb_instr  output  32  head instruction; NOP 32'h00000013 when o_fb_valid=0
- o_fb_pc  output  XLEN  head PC; 0 when o_fb_valid=0
- o_fb_if_illegal  output  1  head entry is illegal from fetch; 0 when o_fb_valid=0
- i_fb_ready  input  1  decode accepts the head entry this cycle (low means stall)

## Operation
- Accept condition: i_fb_mem_valid & o_fb_mem_ready.
- Matching epoch (i_fb_mem_epoch == o_fb_epoch): the response is pushed.
- Mismatching epoch: the response is consumed (handshake completes) and dropped; nothing is pushed.
- Entry fields: instr, pc, illegal. illegal = mem_fault | (pc[1:0] != 0) | (instr[1:0] != 2'b11). Compressed instructions are not supported and are flagged illegal.
- Pop condition: o_fb_valid & i_fb_ready.
- o_fb_mem_ready = !full. A full buffer does not accept a push, even in a cycle where it pops.
- Not full: push and pop in the same cycle are both performed and count is unchanged.
- Count range 0..DEPTH, width $clog2(DEPTH+1). Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- o_fb_valid = (count != 0). Outputs are driven combinationally from the head entry (first-word fall-through); invalid head outputs are forced to NOP/0/0.
- Flush has priority over push and pop in the same cycle. On the next edge:
  - count, read pointer and write pointer clear to 0;
  - the same-cycle push is dropped;
  - the same-cycle pop has no effect;
  - the epoch toggles.
- Back-to-back flushes toggle the epoch every cycle.
- The stored illegal bit is forwarded unchanged. This block does not decode opcodes.

## Timing
- Reset (asynchronous assert, synchronous release): count=0, pointers=0, epoch=0. Outputs: o_fb_valid=0, o_fb_instr=32'h00000013, o_fb_pc=0, o_fb_if_illegal=0, o_fb_mem_ready=1, o_fb_epoch=0.
- Asserting reset mid-operation clears state immediately, without waiting for a clock edge.
- Latency: a response accepted at edge N appears on o_fb_valid after edge N into an empty buffer, i.e. one cycle.
- Throughput: one instruction per cycle with DEPTH≥2 and decode never stalling.
- Flush sampled at edge N: o_fb_valid=0 and o_fb_epoch inverted after edge N. Responses carrying the old epoch are dropped from then on.
- o_fb_mem_ready depends only on registered count. There is no combinational path from i_fb_ready to o_fb_mem_ready.
- Storage registers need no reset. Only count, pointers and epoch are reset.

## Structure
- Shared package core_pkg holds:
  - constant NOP_INSTR = 32'h00000013;
  - typedef struct fetch_entry_t {instr[31:0], pc[XLEN-1:0], illegal}.
- One natural sub-module: core_sync_fifo. It is a parameterised width/depth FIFO with push, pop, clear, full, empty and count, and it stores fetch_entry_t.
- core_fetch_buffer adds the epoch register, illegal computation, stale-response drop and output masking around it.
- o_fb_instr and o_fb_if_illegal drive the decode top's i_instr and i_main_decoder_if_illegal.

## Test plan
- Reset then idle → o_fb_valid=0, o_fb_instr=0x00000013, o_fb_mem_ready=1, o_fb_epoch=0.
- Push 0x00500093 @pc 0x1000 with decode ready → after 1 cycle o_fb_valid=1, instr 0x00500093, pc 0x1000, if_illegal=0; popped the next cycle.
- Stall decode and push 3 words (DEPTH=2) → o_fb_mem_ready=0 after the 2nd push; the 3rd word is held off. Release the stall → words come out in order, 0x1000 then 0x1004, then the 3rd word is accepted.
- Push with fault=1; then pc 0x1002; then instr 0x00004501 → o_fb_if_illegal=1 for each of the three.
- Buffer holds 2 entries; assert flush in the same cycle as a push → next cycle o_fb_valid=0 and epoch=1. A following response with epoch 0 is accepted (ready=1) but never appears; a response with epoch 1 appears after 1 cycle.
- Assert i_rst_n low asynchronously mid-cycle with 2 entries buffered → o_fb_valid falls before the next edge and epoch returns to 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the fetch buffer slice.
package core_pkg;

    localparam int XLEN = 64;

    // Canonical RISC-V NOP (addi x0, x0, 0) shown to decode when nothing is buffered.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } fetch_entry_t;

    // Fetch-side illegal: access fault, misaligned PC, or a compressed encoding (unsupported).
    function automatic logic fetch_illegal(input logic       fault,
                                           input logic [1:0] pc_lo,
                                           input logic [1:0] instr_lo);
        return fault | (pc_lo != 2'b00) | (instr_lo != 2'b11);
    endfunction

endpackage

// File: rtl/core_fetch_buffer_if.sv
// Memory-response and decode-side handshake bundle of the fetch buffer.
interface core_fetch_buffer_if;
    import core_pkg::*;

    logic            i_fb_flush;
    logic            i_fb_mem_valid;
    logic [31:0]     i_fb_mem_instr;
    logic [XLEN-1:0] i_fb_mem_pc;
    logic            i_fb_mem_fault;
    logic            i_fb_mem_epoch;
    logic            o_fb_mem_ready;
    logic            o_fb_epoch;
    logic            o_fb_valid;
    logic [31:0]     o_fb_instr;
    logic [XLEN-1:0] o_fb_pc;
    logic            o_fb_if_illegal;
    logic            i_fb_ready;

    // Environment side: drives memory responses, flush and decode ready.
    modport master (
        output i_fb_flush, i_fb_mem_valid, i_fb_mem_instr, i_fb_mem_pc,
               i_fb_mem_fault, i_fb_mem_epoch, i_fb_ready,
        input  o_fb_mem_ready, o_fb_epoch, o_fb_valid, o_fb_instr,
               o_fb_pc, o_fb_if_illegal
    );

    // Buffer side.
    modport slave (
        input  i_fb_flush, i_fb_mem_valid, i_fb_mem_instr, i_fb_mem_pc,
               i_fb_mem_fault, i_fb_mem_epoch, i_fb_ready,
        output o_fb_mem_ready, o_fb_epoch, o_fb_valid, o_fb_instr,
               o_fb_pc, o_fb_if_illegal
    );

endinterface

// File: rtl/core_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read, synchronous clear and
// occupancy count. DEPTH must be a power of two (pointers wrap naturally).
module core_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    // A full FIFO refuses a push even when it pops in the same cycle.
    assign push_ok_s = push & ~full & ~clear;
    assign pop_ok_s  = pop & ~empty & ~clear;

    // Next pointer/count values; clear wins over push and pop.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        if (clear) begin
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Control state: pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/core_fetch_buffer.sv
// Fetch buffer between instruction-memory responses and decode. Tags the
// pipeline with a 1-bit epoch so responses issued before a redirect are dropped.
module core_fetch_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    core_fetch_buffer_if.slave  fb
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             epoch_r;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             valid_s;
    logic             full_s;
    logic             fifo_empty_unused_s;
    logic [CNT_W-1:0] count_s;
    fetch_entry_t     wr_entry_s;
    fetch_entry_t     rd_entry_s;

    // Stale responses still complete the handshake but are never stored.
    assign accept_s = fb.i_fb_mem_valid & ~full_s;
    assign push_s   = accept_s & (fb.i_fb_mem_epoch == epoch_r);
    assign valid_s  = (count_s != {CNT_W{1'b0}});
    assign pop_s    = valid_s & fb.i_fb_ready;

    assign wr_entry_s.instr   = fb.i_fb_mem_instr;
    assign wr_entry_s.pc      = fb.i_fb_mem_pc;
    assign wr_entry_s.illegal = fetch_illegal(fb.i_fb_mem_fault, fb.i_fb_mem_pc[1:0],
                                              fb.i_fb_mem_instr[1:0]);

    // Ready comes from registered occupancy only, never from decode ready.
    assign fb.o_fb_mem_ready = ~full_s;
    assign fb.o_fb_epoch     = epoch_r;

    core_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (fb.i_fb_flush),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wr_entry_s),
        .rdata (rd_entry_s),
        .full  (full_s),
        .empty (fifo_empty_unused_s),
        .count (count_s)
    );

    // Epoch flips on every flush, including back-to-back flushes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            epoch_r <= 1'b0;
        end else if (fb.i_fb_flush) begin
            epoch_r <= ~epoch_r;
        end else begin
            epoch_r <= epoch_r;
        end
    end

    // Present the head entry, masked to NOP/0/0 when nothing is buffered.
    always_comb begin
        fb.o_fb_valid      = 1'b0;
        fb.o_fb_instr      = NOP_INSTR;
        fb.o_fb_pc         = {XLEN{1'b0}};
        fb.o_fb_if_illegal = 1'b0;
        if (valid_s) begin
            fb.o_fb_valid      = 1'b1;
            fb.o_fb_instr      = rd_entry_s.instr;
            fb.o_fb_pc         = rd_entry_s.pc;
            fb.o_fb_if_illegal = rd_entry_s.illegal;
        end else begin
            fb.o_fb_valid      = 1'b0;
        end
    end

endmodule

// File: tb/tb_core_fetch_buffer.sv
// Directed, table-driven bench for core_fetch_buffer (DEPTH=2).
module tb_core_fetch_buffer;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic        flush;
        logic        mv;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        fault;
        logic        ep;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic        e_ill;
        logic        e_mrdy;
        logic        e_ep;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;
    vec_t vecs[$];

    core_fetch_buffer_if fb();

    core_fetch_buffer #(.DEPTH(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .fb      (fb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic fl, input logic mv, input logic [31:0] ins,
                       input logic [63:0] pc, input logic flt, input logic ep,
                       input logic rdy, input logic ev, input logic [31:0] ei,
                       input logic [63:0] epc, input logic eil, input logic emr,
                       input logic eep);
        vec_t v;
        v.flush = fl; v.mv = mv; v.instr = ins; v.pc = pc; v.fault = flt;
        v.ep = ep; v.rdy = rdy; v.e_valid = ev; v.e_instr = ei; v.e_pc = epc;
        v.e_ill = eil; v.e_mrdy = emr; v.e_ep = eep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s (vec %0d): got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic mv, input logic [31:0] ins,
                         input logic [63:0] pc, input logic flt, input logic ep,
                         input logic rdy);
        fb.i_fb_flush     = fl;
        fb.i_fb_mem_valid = mv;
        fb.i_fb_mem_instr = ins;
        fb.i_fb_mem_pc    = pc;
        fb.i_fb_mem_fault = flt;
        fb.i_fb_mem_epoch = ep;
        fb.i_fb_ready     = rdy;
    endtask

    task automatic check_outs(input int idx, input logic ev, input logic [31:0] ei,
                              input logic [63:0] epc, input logic eil,
                              input logic emr, input logic eep);
        n_vec++;
        chk("valid",     idx, 64'(fb.o_fb_valid),      64'(ev));
        chk("instr",     idx, 64'(fb.o_fb_instr),      64'(ei));
        chk("pc",        idx, fb.o_fb_pc,              epc);
        chk("illegal",   idx, 64'(fb.o_fb_if_illegal), 64'(eil));
        chk("mem_ready", idx, 64'(fb.o_fb_mem_ready),  64'(emr));
        chk("epoch",     idx, 64'(fb.o_fb_epoch),      64'(eep));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // Each row: inputs held for one cycle; expected outputs are those seen
        // while the inputs are applied, i.e. the state left by earlier rows.
        //   fl mv instr          pc        flt ep rdy | v  instr          pc        il mr ep
        add(0, 0, 32'h0,        64'h0,    0, 0, 0,   0, NOP,           64'h0,    0, 1, 0); // 0 idle
        add(0, 1, 32'h00500093, 64'h1000, 0, 0, 1,   0, NOP,           64'h0,    0, 1, 0); // 1 push
        add(0, 0, 32'h0,        64'h0,    0, 0, 1,   1, 32'h00500093,  64'h1000, 0, 1, 0); // 2 head, pop
        add(0, 0, 32'h0,        64'h0,    0, 0, 0,   0, NOP,           64'h0,    0, 1, 0); // 3 empty
        add(0, 1, 32'h00100113, 64'h1000, 0, 0, 0,   0, NOP,           64'h0,    0, 1, 0); // 4 stall push A
        add(0, 1, 32'h00200193, 64'h1004, 0, 0, 0,   1, 32'h00100113,  64'h1000, 0, 1, 0); // 5 push B
        add(0, 1, 32'h00300213, 64'h1008, 0, 0, 0,   1, 32'h00100113,  64'h1000, 0, 0, 0); // 6 C held off
        add(0, 1, 32'h00300213, 64'h1008, 0, 0, 1,   1, 32'h00100113,  64'h1000, 0, 0, 0); // 7 pop A, no push
        add(0, 1, 32'h00300213, 64'h1008, 0, 0, 1,   1, 32'h00200193,  64'h1004, 0, 1, 0); // 8 pop B, push C
        add(0, 0, 32'h0,        64'h0,    0, 0, 1,   1, 32'h00300213,  64'h1008, 0, 1, 0); // 9 pop C
        add(0, 1, 32'h00500093, 64'h2000, 1, 0, 1,   0, NOP,           64'h0,    0, 1, 0); // 10 fault
        add(0, 1, 32'h00500093, 64'h2002, 0, 0, 1,   1, 32'h00500093,  64'h2000, 1, 1, 0); // 11 misaligned pc
        add(0, 1, 32'h00004501, 64'h2004, 0, 0, 1,   1, 32'h00500093,  64'h2002, 1, 1, 0); // 12 compressed
        add(0, 0, 32'h0,        64'h0,    0, 0, 1,   1, 32'h00004501,  64'h2004, 1, 1, 0); // 13
        add(0, 0, 32'h0,        64'h0,    0, 0, 0,   0, NOP,           64'h0,    0, 1, 0); // 14
        add(0, 1, 32'h00a00513, 64'h3000, 0, 0, 0,   0, NOP,           64'h0,    0, 1, 0); // 15 push D
        add(0, 1, 32'h00b00593, 64'h3004, 0, 0, 0,   1, 32'h00a00513,  64'h3000, 0, 1, 0); // 16 push E
        add(1, 1, 32'h00c00613, 64'h3008, 0, 0, 1,   1, 32'h00a00513,  64'h3000, 0, 0, 0); // 17 flush+push+pop
        add(0, 1, 32'h00c00613, 64'h4000, 0, 0, 1,   0, NOP,           64'h0,    0, 1, 1); // 18 stale ep0
        add(0, 1, 32'h00d00693, 64'h4004, 0, 1, 1,   0, NOP,           64'h0,    0, 1, 1); // 19 ep1 push
        add(0, 0, 32'h0,        64'h0,    0, 0, 1,   1, 32'h00d00693,  64'h4004, 0, 1, 1); // 20 appears
        add(1, 1, 32'h00e00713, 64'h5000, 0, 1, 1,   0, NOP,           64'h0,    0, 1, 1); // 21 flush drops push
        add(1, 0, 32'h0,        64'h0,    0, 0, 1,   0, NOP,           64'h0,    0, 1, 0); // 22 2nd flush
        add(0, 0, 32'h0,        64'h0,    0, 0, 1,   0, NOP,           64'h0,    0, 1, 1); // 23
        add(0, 0, 32'h0,        64'h0,    0, 0, 1,   0, NOP,           64'h0,    0, 1, 1); // 24

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].flush, vecs[i].mv, vecs[i].instr, vecs[i].pc,
                  vecs[i].fault, vecs[i].ep, vecs[i].rdy);
            #1;
            check_outs(i, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc,
                       vecs[i].e_ill, vecs[i].e_mrdy, vecs[i].e_ep);
        end

        // Asynchronous reset mid-cycle with two entries buffered (epoch is 1 here).
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h00f00793, 64'h6000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h01000813, 64'h6004, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check_outs(100, 1'b1, 32'h00f00793, 64'h6000, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs(101, 1'b0, NOP, 64'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_outs(102, 1'b0, NOP, 64'h0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
